// File: rtl/q100_dtcm_host_bridge_pkg.sv
// Shared types for the q100 DTCM host bridge: FSM state, counter width, byte-lane merge.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package q100_bridge_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bridge_state_t;

    localparam int RUN_CNT_WIDTH = 32;

    // Widest word the merge helper handles; narrower words are zero-extended by the caller.
    localparam int MAX_BANK = 8;

    typedef logic [8*MAX_BANK-1:0] lane_word_t;
    typedef logic [MAX_BANK-1:0]   lane_be_t;

    // Replace the byte lanes selected by be with the matching lanes of new_word.
    function automatic lane_word_t lane_merge(input lane_word_t old_word,
                                              input lane_word_t new_word,
                                              input lane_be_t   be);
        lane_word_t merged;
        merged = old_word;
        for (int b = 0; b < MAX_BANK; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/q100_dtcm_host_bridge_if.sv
// Host-side request/response channel of the DTCM bridge (loader/DMA access).
// Latency: read data returns the cycle after the request is accepted.
// Backpressure: req valid/ready; response held until rsp_valid & rsp_ready.
// Ports: req_valid/ready/we/be/addr/wdata (host -> bridge), rsp_valid/ready/rdata (bridge -> host).
interface q100_dtcm_host_bridge_if #(
    parameter int BANK       = 4,
    parameter int ADDR_WIDTH = 12
);
    localparam int DATA_WIDTH = 8 * BANK;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [BANK-1:0]       req_be;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/q100_dtcm_host_bridge_bank_ram.sv
// Single-port byte-lane RAM with per-lane write enables and a read-first output register.
// Latency: rdata valid 1 cycle after addr with re=1; holds otherwise.
// Backpressure: none (accepts an access every cycle).
// Ports: clk, rst (clears only the output register), addr, we[BANK], wdata, re, rdata.
module q100_bank_ram
    import q100_bridge_pkg::*;
#(
    parameter int BANK       = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8 * BANK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BANK-1:0]       we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Contents survive reset so a held core can be restarted on preloaded data.
    always_ff @(posedge clk) begin
        if (|we) begin
            mem[addr] <= DATA_WIDTH'(lane_merge(lane_word_t'(mem[addr]),
                                                lane_word_t'(wdata),
                                                lane_be_t'(we)));
        end
    end

    // Non-blocking read of the pre-write word gives read-first behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/q100_dtcm_host_bridge.sv
// External DTCM responder for q100_core: core owns storage in RUN, host owns it in LOAD/DONE.
// Latency: core and host reads return 1 cycle after the address; writes land on the clock edge.
// Backpressure: host requests stall (ready=0) in RUN or while a read response is unaccepted.
// Ports: clk, rst (async low), core dtcm_* port, done_intr_i/core_hold_o, host_start_i,
//        host channel (interface), busy_o/done_o/timeout_o status, run_cycles_o counter.
module q100_dtcm_host_bridge
    import q100_bridge_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int          BANK           = 4,
    parameter int          ADDR_WIDTH     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_WIDTH-1:0]    dtcm_addr_i,
    input  logic [BANK-1:0]          dtcm_we_i,
    input  logic [DATA_WIDTH-1:0]    dtcm_data_i,
    output logic [DATA_WIDTH-1:0]    dtcm_data_o,
    input  logic                     done_intr_i,
    output logic                     core_hold_o,
    input  logic                     host_start_i,
    q100_dtcm_host_bridge_if.slave   host,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic [RUN_CNT_WIDTH-1:0] run_cycles_o
);

    bridge_state_t state_q, state_d;

    logic                     in_run;
    logic                     start_ok;
    logic                     wd_hit;
    logic                     enter_run;
    logic                     req_ready;
    logic                     host_acc;

    logic [ADDR_WIDTH-1:0]    ram_addr;
    logic [BANK-1:0]          ram_we;
    logic [DATA_WIDTH-1:0]    ram_wdata;
    logic                     ram_re;
    logic [DATA_WIDTH-1:0]    ram_rdata;

    logic                     rsp_valid_q;
    logic                     core_rd_q;
    logic [DATA_WIDTH-1:0]    dtcm_hold_q;
    logic [RUN_CNT_WIDTH-1:0] run_cnt_q;
    logic                     timeout_q;

    assign in_run    = (state_q == RUN);
    // A start while a read response is still outstanding is dropped, not queued.
    assign start_ok  = host_start_i & ~rsp_valid_q;
    assign wd_hit    = (TIMEOUT_CYCLES != 0) &&
                       (({1'b0, run_cnt_q} + 33'd1) == 33'(TIMEOUT_CYCLES));
    assign enter_run = ~in_run & (state_d == RUN);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD, DONE: if (start_ok) state_d = RUN;
            RUN:        if (done_intr_i || wd_hit) state_d = DONE;
            default:    state_d = LOAD;
        endcase
    end

    // ---------------- FSM: outputs (decoded from the state register) ----------------
    always_comb begin
        core_hold_o = (state_q != RUN);
        busy_o      = (state_q == RUN);
        done_o      = (state_q == DONE);
    end

    // ---------------- Host channel ----------------
    // Start has priority over a same-cycle request so the core never races a host access.
    assign req_ready      = ~in_run & ~host_start_i & (~rsp_valid_q | host.rsp_ready);
    assign host_acc       = host.req_valid & req_ready;
    assign host.req_ready = req_ready;
    assign host.rsp_valid = rsp_valid_q;
    // Only accepted host reads move the RAM output register outside RUN, so it is stable
    // for as long as the response waits.
    assign host.rsp_rdata = ram_rdata;

    // ---------------- Storage access mux ----------------
    assign ram_addr  = in_run ? dtcm_addr_i : host.req_addr;
    assign ram_we    = in_run ? dtcm_we_i : ({BANK{host_acc & host.req_we}} & host.req_be);
    assign ram_wdata = in_run ? dtcm_data_i : host.req_wdata;
    assign ram_re    = in_run | (host_acc & ~host.req_we);

    q100_bank_ram #(
        .BANK       (BANK),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    // Core sees fresh RAM data the cycle after a RUN read, otherwise the last such value,
    // so host traffic in LOAD/DONE never disturbs the core's read bus.
    assign dtcm_data_o = core_rd_q ? ram_rdata : dtcm_hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            core_rd_q   <= 1'b0;
            dtcm_hold_q <= '0;
        end else begin
            core_rd_q <= in_run;
            if (core_rd_q) begin
                dtcm_hold_q <= ram_rdata;
            end
            if (host_acc && !host.req_we) begin
                rsp_valid_q <= 1'b1;
            end else if (host.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // ---------------- Run counter and watchdog flag ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (enter_run) begin
                run_cnt_q <= '0;
            end else if (in_run && (run_cnt_q != '1)) begin
                run_cnt_q <= run_cnt_q + RUN_CNT_WIDTH'(1);
            end

            if (enter_run) begin
                timeout_q <= 1'b0;
            end else if (in_run && (state_d == DONE)) begin
                // A done interrupt in the same cycle as the watchdog counts as a clean finish.
                timeout_q <= ~done_intr_i;
            end
        end
    end

    assign run_cycles_o = run_cnt_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_q100_dtcm_host_bridge.sv
module tb_q100_dtcm_host_bridge;

    logic        clk;
    logic        rst;
    logic [11:0] dtcm_addr;
    logic [3:0]  dtcm_we;
    logic [31:0] dtcm_wdata;
    logic        done_intr;
    logic        start_a, start_b;
    logic [3:0]  no_we;
    logic        no_done;

    logic [31:0] rd_a, rd_b, run_a, run_b;
    logic        hold_a, busy_a, done_a, to_a;
    logic        hold_b, busy_b, done_b, to_b;

    q100_dtcm_host_bridge_if #(.BANK(4), .ADDR_WIDTH(12)) h ();
    q100_dtcm_host_bridge_if #(.BANK(4), .ADDR_WIDTH(12)) hb ();

    q100_dtcm_host_bridge #(.DATA_WIDTH(32), .BANK(4), .ADDR_WIDTH(12), .TIMEOUT_CYCLES(0)) dut (
        .clk(clk), .rst(rst),
        .dtcm_addr_i(dtcm_addr), .dtcm_we_i(dtcm_we), .dtcm_data_i(dtcm_wdata), .dtcm_data_o(rd_a),
        .done_intr_i(done_intr), .core_hold_o(hold_a), .host_start_i(start_a), .host(h),
        .busy_o(busy_a), .done_o(done_a), .timeout_o(to_a), .run_cycles_o(run_a)
    );

    q100_dtcm_host_bridge #(.DATA_WIDTH(32), .BANK(4), .ADDR_WIDTH(12), .TIMEOUT_CYCLES(20)) dut_wd (
        .clk(clk), .rst(rst),
        .dtcm_addr_i(dtcm_addr), .dtcm_we_i(no_we), .dtcm_data_i(dtcm_wdata), .dtcm_data_o(rd_b),
        .done_intr_i(no_done), .core_hold_o(hold_b), .host_start_i(start_b), .host(hb),
        .busy_o(busy_b), .done_o(done_b), .timeout_o(to_b), .run_cycles_o(run_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference storage: word address -> expected contents.
    logic [31:0] mem_m [int];

    typedef struct {
        bit          we;
        logic [3:0]  be;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        int          stall;
        string       nm;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [31:0] merge_m(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int w;
        w = 0;
        #1;
        while (!h.req_ready && w < 20) begin
            tick();
            w++;
        end
        if (!h.req_ready) chk({nm, "_rdy"}, 32'(h.req_ready), 32'd1);
    endtask

    task automatic host_write(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
        h.req_valid = 1'b1; h.req_we = 1'b1; h.req_addr = a; h.req_be = be; h.req_wdata = d;
        h.rsp_ready = 1'b1;
        wait_ready("wr");
        tick();
        h.req_valid = 1'b0; h.req_we = 1'b0;
        mem_m[int'(a)] = merge_m(mem_m.exists(int'(a)) ? mem_m[int'(a)] : 32'h0, d, be);
    endtask

    task automatic host_read(input logic [11:0] a, input logic [31:0] exp, input int stall,
                             input string nm);
        h.req_valid = 1'b1; h.req_we = 1'b0; h.req_addr = a; h.req_be = '0; h.rsp_ready = 1'b1;
        wait_ready(nm);
        tick();
        h.req_valid = 1'b0;
        h.rsp_ready = (stall == 0);
        chk({nm, "_vld"}, 32'(h.rsp_valid), 32'd1);
        chk(nm, h.rsp_rdata, exp);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({nm, "_hold"}, h.rsp_rdata, exp);
        end
        h.rsp_ready = 1'b1;
        tick();
        chk({nm, "_end"}, 32'(h.rsp_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [11:0] a;
        logic [3:0]  we;
        logic [31:0] d, e, last_core;
        int          exp_run;

        tbl[0] = '{1'b1, 4'hF, 12'h010, 32'hDEADBEEF, 32'h0,         0, "wr_full"};
        tbl[1] = '{1'b1, 4'h1, 12'h010, 32'h000000AA, 32'h0,         0, "wr_lane0"};
        tbl[2] = '{1'b0, 4'h0, 12'h010, 32'h0,        32'hDEADBEAA, 0, "rd_merge"};
        tbl[3] = '{1'b1, 4'hF, 12'hFFF, 32'h0BADF00D, 32'h0,         0, "wr_top"};
        tbl[4] = '{1'b1, 4'hF, 12'h000, 32'hCAFEF00D, 32'h0,         0, "wr_zero"};
        tbl[5] = '{1'b1, 4'h6, 12'h000, 32'h11223344, 32'h0,         0, "wr_lane12"};
        tbl[6] = '{1'b0, 4'h0, 12'hFFF, 32'h0,        32'h0BADF00D, 1, "rd_top"};
        tbl[7] = '{1'b0, 4'h0, 12'h000, 32'h0,        32'hCA22330D, 0, "rd_lane12"};
        tbl[8] = '{1'b1, 4'h8, 12'h001, 32'h55FFFFFF, 32'h0,         0, "wr_lane3"};
        tbl[9] = '{1'b0, 4'h0, 12'h001, 32'h0,        32'h55000000, 2, "rd_lane3"};

        rst = 1'b0; dtcm_addr = '0; dtcm_we = '0; dtcm_wdata = '0; done_intr = 1'b0;
        start_a = 1'b0; start_b = 1'b0; no_we = '0; no_done = 1'b0;
        h.req_valid = 1'b0; h.req_we = 1'b0; h.req_be = '0; h.req_addr = '0; h.req_wdata = '0;
        h.rsp_ready = 1'b1;
        hb.req_valid = 1'b0; hb.req_we = 1'b0; hb.req_be = '0; hb.req_addr = '0;
        hb.req_wdata = '0; hb.rsp_ready = 1'b1;
        tick(); tick();

        chk("rst_hold",  32'(hold_a), 32'd1);
        chk("rst_busy",  32'(busy_a), 32'd0);
        chk("rst_done",  32'(done_a), 32'd0);
        chk("rst_run",   run_a, 32'd0);
        chk("rst_to",    32'(to_a), 32'd0);
        chk("rst_rspv",  32'(h.rsp_valid), 32'd0);
        chk("rst_dtcm",  rd_a, 32'd0);
        rst = 1'b1;
        tick();

        // Table-driven host accesses.
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].we) host_write(tbl[i].addr, tbl[i].be, tbl[i].data);
            else           host_read(tbl[i].addr, tbl[i].exp, tbl[i].stall, tbl[i].nm);
        end

        // Back-to-back reads: one word per cycle.
        h.req_valid = 1'b1; h.req_we = 1'b0; h.req_addr = 12'h000; h.rsp_ready = 1'b1;
        wait_ready("b2b");
        tick();
        h.req_addr = 12'hFFF;
        #1;
        chk("b2b_rdy",  32'(h.req_ready), 32'd1);
        chk("b2b_d0",   h.rsp_rdata, 32'hCA22330D);
        tick();
        h.req_valid = 1'b0;
        chk("b2b_v1",   32'(h.rsp_valid), 32'd1);
        chk("b2b_d1",   h.rsp_rdata, 32'h0BADF00D);
        tick();
        chk("b2b_end",  32'(h.rsp_valid), 32'd0);

        // Randomized host traffic against the reference storage.
        for (int i = 0; i < 16; i++) host_write(12'h100 + 12'(i), 4'hF, $urandom);
        for (int i = 0; i < 40; i++) begin
            a = 12'h100 + 12'($urandom_range(15, 0));
            if ($urandom_range(1, 0) == 1) host_write(a, 4'($urandom), $urandom);
            else host_read(a, mem_m[int'(a)], $urandom_range(2, 0), "rnd_rd");
        end

        // Response stall; start during the stall must be ignored.
        h.req_valid = 1'b1; h.req_we = 1'b0; h.req_addr = 12'h010; h.rsp_ready = 1'b0;
        wait_ready("stall");
        tick();
        chk("stall_v0", 32'(h.rsp_valid), 32'd1);
        chk("stall_d0", h.rsp_rdata, 32'hDEADBEAA);
        h.req_addr = 12'h000;
        for (int i = 0; i < 3; i++) begin
            start_a = (i == 1);
            #1;
            chk("stall_rdy", 32'(h.req_ready), 32'd0);
            tick();
            start_a = 1'b0;
            chk("stall_v", 32'(h.rsp_valid), 32'd1);
            chk("stall_d", h.rsp_rdata, 32'hDEADBEAA);
            chk("stall_nostart", 32'(busy_a), 32'd0);
        end
        h.req_valid = 1'b0; h.rsp_ready = 1'b1;
        tick();
        chk("stall_end", 32'(h.rsp_valid), 32'd0);
        chk("stall_hold", 32'(hold_a), 32'd1);

        // Run: core read, read-first write, then read back.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("run_busy", 32'(busy_a), 32'd1);
        chk("run_hold", 32'(hold_a), 32'd0);
        chk("run_cnt0", run_a, 32'd0);
        dtcm_addr = 12'h010; dtcm_we = 4'h0;
        tick();
        chk("core_rd", rd_a, 32'hDEADBEAA);
        dtcm_we = 4'hC; dtcm_wdata = 32'h12340000;
        tick();
        chk("core_rdfirst", rd_a, 32'hDEADBEAA);
        mem_m[16] = merge_m(mem_m[16], 32'h12340000, 4'hC);
        dtcm_we = 4'h0;
        tick();
        chk("core_wr", rd_a, 32'h1234BEAA);
        exp_run = 3;
        chk("run_cnt3", run_a, 32'(exp_run));

        // Host request pending through RUN must stall, not drop.
        h.req_valid = 1'b1; h.req_we = 1'b0; h.req_addr = 12'h100; h.rsp_ready = 1'b1;
        while (exp_run < 50) begin
            a  = 12'h100 + 12'($urandom_range(15, 0));
            we = ($urandom_range(1, 0) == 1) ? 4'($urandom) : 4'h0;
            d  = $urandom;
            dtcm_addr = a; dtcm_we = we; dtcm_wdata = d;
            e = mem_m[int'(a)];
            mem_m[int'(a)] = merge_m(e, d, we);
            #1;
            chk("run_rdy", 32'(h.req_ready), 32'd0);
            tick();
            exp_run++;
            chk("core_rnd", rd_a, e);
        end
        chk("run_cnt50", run_a, 32'd50);

        // Done cycle also carries a core write.
        dtcm_addr = 12'h10F; dtcm_we = 4'hF; dtcm_wdata = 32'h5A5A0F0F; done_intr = 1'b1;
        last_core = mem_m[271];
        mem_m[271] = 32'h5A5A0F0F;
        tick();
        done_intr = 1'b0; dtcm_we = 4'h0;
        chk("done_done", 32'(done_a), 32'd1);
        chk("done_hold", 32'(hold_a), 32'd1);
        chk("done_busy", 32'(busy_a), 32'd0);
        chk("done_run",  run_a, 32'd51);
        chk("done_to",   32'(to_a), 32'd0);
        chk("done_rd",   rd_a, last_core);
        tick();
        h.req_valid = 1'b0;
        chk("pend_v", 32'(h.rsp_valid), 32'd1);
        chk("pend_d", h.rsp_rdata, mem_m[256]);
        tick();
        dtcm_addr = 12'h10F; dtcm_we = 4'hF; dtcm_wdata = 32'h0;
        tick();
        dtcm_we = 4'h0;
        host_read(12'h010, 32'h1234BEAA, 0, "done_rd010");
        host_read(12'h10F, 32'h5A5A0F0F, 0, "done_wr_kept");
        chk("dtcm_frozen", rd_a, last_core);
        chk("run_frozen", run_a, 32'd51);

        // Watchdog instance.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("wd_busy", 32'(busy_b), 32'd1);
        chk("wd_cnt0", run_b, 32'd0);
        repeat (19) tick();
        chk("wd_pre_busy", 32'(busy_b), 32'd1);
        chk("wd_pre_cnt", run_b, 32'd19);
        tick();
        chk("wd_done", 32'(done_b), 32'd1);
        chk("wd_to",   32'(to_b), 32'd1);
        chk("wd_cnt",  run_b, 32'd20);
        chk("wd_hold", 32'(hold_b), 32'd1);
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("wd_re_to",  32'(to_b), 32'd0);
        chk("wd_re_cnt", run_b, 32'd0);
        repeat (5) tick();
        chk("wd_re_cnt5", run_b, 32'd5);

        // Asynchronous reset in the middle of a run.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        dtcm_addr = 12'h100; dtcm_we = 4'h0;
        repeat (3) tick();
        chk("run2_busy", 32'(busy_a), 32'd1);
        chk("run2_rd", rd_a, mem_m[256]);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_hold", 32'(hold_a), 32'd1);
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_done", 32'(done_a), 32'd0);
        chk("arst_run",  run_a, 32'd0);
        chk("arst_to",   32'(to_a), 32'd0);
        chk("arst_dtcm", rd_a, 32'd0);
        chk("arst_rspv", 32'(h.rsp_valid), 32'd0);
        chk("arst_rspd", h.rsp_rdata, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        host_read(12'h010, 32'h1234BEAA, 0, "rst_keep010");
        host_read(12'h10F, 32'h5A5A0F0F, 1, "rst_keep10F");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/q100_dtcm_host_bridge.md
Name: q100_dtcm_host_bridge

Overview:
- External DTCM responder for a q100_core built with EXT_DTCM=1.
- Services the core's external DTCM port (addr/we/dout out, din in) with byte-banked storage and 1-cycle read latency.
- Gives a host (loader/DMA) valid/ready access to the same storage while the core is held in reset.
- Sequences load -> run -> done, with a run-cycle counter and a watchdog timeout.

Parameters:
- DATA_WIDTH, 32, word width; equals `DTCM_DATA_WIDTH.
- BANK, 4, byte lanes; equals `DTCM_BANK. DATA_WIDTH = 8*BANK.
- ADDR_WIDTH, 12, word-address bits used (storage depth 2**ADDR_WIDTH words).
- TIMEOUT_CYCLES, 0, watchdog limit in RUN cycles; 0 disables.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- dtcm_addr_i  in  ADDR_WIDTH  core word address (core dtcm_addr_o low bits).
- dtcm_we_i  in  BANK  core per-byte write enables.
- dtcm_data_i  in  DATA_WIDTH  core write data.
- dtcm_data_o  out  DATA_WIDTH  read data to core dtcm_din_i.
- done_intr_i  in  1  core done interrupt.
- core_hold_o  out  1  1 = keep core in reset.
- host_start_i  in  1  single-cycle pulse: release core.
- host_req_valid_i  in  1  host request valid.
- host_req_ready_o  out  1  host request accepted when valid&ready.
- host_req_we_i  in  1  1 = write, 0 = read.
- host_req_be_i  in  BANK  write byte enables.
- host_req_addr_i  in  ADDR_WIDTH  word address.
- host_req_wdata_i  in  DATA_WIDTH  write data.
- host_rsp_valid_o  out  1  read data valid.
- host_rsp_ready_i  in  1  host accepts read data.
- host_rsp_rdata_o  out  DATA_WIDTH  read data.
- busy_o  out  1  state==RUN.
- done_o  out  1  state==DONE.
- timeout_o  out  1  last run ended by watchdog.
- run_cycles_o  out  32  cycles spent in the last or current RUN.

Behaviour:
- Reset (rst=0, asynchronous): state=LOAD.
  - core_hold_o=1, host_rsp_valid_o=0, busy_o=0, done_o=0, timeout_o=0, run_cycles_o=0, dtcm_data_o=0, host_rsp_rdata_o=0.
  - Storage contents are not reset.
- Reset asserted mid-transfer or mid-run aborts everything. A pending response is dropped.
- States: LOAD, RUN, DONE.
  - LOAD -> RUN: host_start_i=1 and host_rsp_valid_o=0. Otherwise start is ignored (not queued).
  - RUN -> DONE: done_intr_i=1; timeout_o<=0.
  - RUN -> DONE: TIMEOUT_CYCLES!=0 and run_cycles_o+1==TIMEOUT_CYCLES; timeout_o<=1.
  - done_intr_i wins over timeout in the same cycle (timeout_o=0).
  - DONE -> RUN: host_start_i=1 and host_rsp_valid_o=0. timeout_o is cleared on entry to RUN.
- core_hold_o = (state!=RUN), registered. The core sees at least one hold cycle between runs.
- Storage ownership:
  - RUN: core owns storage.
  - LOAD and DONE: host owns storage; core dtcm_we_i is ignored and dtcm_data_o holds its last value.
- Core port (RUN):
  - Read every cycle. dtcm_data_o valid 1 cycle after dtcm_addr_i.
  - Per-lane write where dtcm_we_i[b]=1.
  - Read-during-write to the same address returns old data (read-first).
  - Writes in the cycle done_intr_i=1 are still performed.
- Host port:
  - host_req_ready_o = (state!=RUN) & ~host_start_i & (~host_rsp_valid_o | host_rsp_ready_i).
  - Accepted write: lanes with host_req_be_i set updated at the clock edge. No response.
  - Accepted read at cycle N: host_rsp_valid_o=1 from N+1, host_rsp_rdata_o = word at N.
    - Data held stable until host_rsp_valid_o & host_rsp_ready_i.
    - Back-to-back reads give one word per cycle when host_rsp_ready_i=1.
- run_cycles_o:
  - Cleared to 0 on the RUN-entry edge.
  - +1 per RUN cycle; saturates at 0xFFFF_FFFF.
  - Frozen in LOAD/DONE.
- Host requests in RUN are stalled (ready=0), never dropped.

Decomposition:
- Package q100_bridge_pkg:
  - bridge_state_t enum {LOAD, RUN, DONE}.
  - RUN_CNT_WIDTH=32.
  - Helper function for byte-lane merge.
- Sub-module q100_bank_ram: single-port, BANK byte lanes, per-lane write enable, synchronous read-first, registered output with read-enable.
- The bridge holds the FSM, the address/data mux, the response hold logic and the counters.

Test Plan:
- Reset -> core_hold_o=1, busy_o=0, done_o=0, run_cycles_o=0. Host writes 0xDEADBEEF @0x010 with be=4'b1111, then be=4'b0001 data 0x000000AA. Host read @0x010 -> rsp 0xDEADBEAA one cycle later.
- Host read with host_rsp_ready_i=0 for 3 cycles -> rsp data and valid held stable, host_req_ready_o=0. host_start_i during the stall is ignored (state stays LOAD).
- host_start_i -> next cycle busy_o=1, core_hold_o=0. Core reads @0x010 -> dtcm_data_o=0xDEADBEAA next cycle. Core write we=4'b1100 0x12340000 @0x010, then read -> 0x1234BEAA.
- 50 RUN cycles, then done_intr_i=1 -> done_o=1, core_hold_o=1, run_cycles_o=51, timeout_o=0. Host read @0x010 -> 0x1234BEAA.
- TIMEOUT_CYCLES=20 and done_intr_i never asserted -> DONE after 20 RUN cycles, timeout_o=1, run_cycles_o=20. Restart with host_start_i -> timeout_o=0, run_cycles_o restarts at 0.
- rst=0 asserted mid-RUN -> outputs immediately at reset values and state=LOAD. Host read @0x010 -> contents preserved.
